data_mem_access_unit: RTL and testbench

MEM-stage responder for the load/store control codes produced by the instruction decoder. It accepts the encoded `mem_read`/`mem_write` commands together with the ALU address and rs2 data. It translates each command into a word-wide request/acknowledge transaction on the data-memory port, using byte enables for stores and lane selection plus sign/zero extension for loads. While a transaction is outstanding it stalls the pipeline, and it returns the load result to the MEM/WB register.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/load_extender.sv | 34 +++
 rtl/data_mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared load/store encodings and the MEM-stage FSM state type.
// Also provides a helper that maps funct3[1:0] to an access size. The same
// mapping covers loads and stores: 00 byte, 01 half, anything else word.
// The "anything else" case is why the unlisted load codes behave as LW.
package cpu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  function automatic size_e access_size(input logic [1:0] f3_lo);
    case (f3_lo)
      F3_SB:   access_size = SZ_BYTE;
      F3_SH:   access_size = SZ_HALF;
      F3_SW:   access_size = SZ_WORD;
      default: access_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load formatter.
// It picks a byte lane (off[1:0]) or a half lane (off[1]) out of a memory
// word, then sign- or zero-extends it according to funct3. Lanes are
// little-endian: byte 0 is word[7:0].
//   word   in  memory read word
//   off    in  byte offset of the access
//   funct3 in  load funct3; unlisted codes pass the word through
//   data   out extended result
module load_extender
  import cpu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  data = {24'h0, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  data = {16'h0, lane_h};
      F3_LW:   data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store responder.
// It turns decoded mem_read/mem_write commands into one word-wide req/ack
// transaction on the data-memory port, stalls the pipeline while the
// transaction is outstanding, and returns extended load data.
//   CLK, RESET          clock; asynchronous active-low reset
//   mem_read[3:0]       {load_en, funct3}
//   mem_write[2:0]      {store_en, funct3[1:0]}
//   address, write_data ALU byte address and rs2 store data
//   read_data           last completed load result
//   busy                combinational stall request
//   misaligned          one-cycle trap flag
//   dmem_*              request/ack memory port, word addressed
// Optional feature: when MISALIGN_TRAP_EN is defined, misaligned half/word
// accesses skip memory and pulse `misaligned`. Otherwise the low address bits
// are simply masked.
module data_mem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            mem_read,
  input  logic [2:0]            mem_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  busy,
  output logic                  misaligned,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-3:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack
);

  localparam int WA = ADDR_WIDTH - 2;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [WA-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            cmd, st_cmd;
  logic [2:0]      f3_in;
  size_e           sz_in;
  logic [3:0]      be_in;
  logic [31:0]     wdata_in;
  logic [31:0]     ext_data;

  // Store wins when both enables are set; the load is dropped.
  assign st_cmd = mem_write[2];
  assign cmd    = mem_write[2] | mem_read[3];
  assign f3_in  = st_cmd ? {1'b0, mem_write[1:0]} : mem_read[2:0];
  assign sz_in  = access_size(f3_in[1:0]);

  // Loads read the whole word (all lanes enabled). Lane selection happens
  // on the way back in load_extender.
  always_comb begin
    be_in    = 4'hF;
    wdata_in = write_data;
    if (st_cmd) begin
      case (sz_in)
        SZ_BYTE: begin
          be_in    = 4'b0001 << address[1:0];
          wdata_in = {4{write_data[7:0]}};
        end
        SZ_HALF: begin
          be_in    = address[1] ? 4'b1100 : 4'b0011;
          wdata_in = {2{write_data[15:0]}};
        end
        default: begin
          be_in    = 4'hF;
          wdata_in = write_data;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic misalign_in;
  assign misalign_in = ((sz_in == SZ_HALF) && address[0]) ||
                       ((sz_in == SZ_WORD) && (address[1:0] != 2'b00));
  assign misaligned  = mis_q;
`else
  assign misaligned  = 1'b0;
`endif

  load_extender u_ext (
    .word   (dmem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd) begin
`ifdef MISALIGN_TRAP_EN
          if (misalign_in) begin
            // Trap: no memory access, straight to the one-cycle DONE.
            state_d = DONE;
            mis_d   = 1'b1;
          end else begin
`else
          begin
`endif
            state_d = ACCESS;
            req_d   = 1'b1;
            we_d    = st_cmd;
            addr_d  = address[ADDR_WIDTH-1:2];
            wdata_d = wdata_in;
            be_d    = be_in;
            f3_d    = f3_in;
            off_d   = address[1:0];
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'h0;
          if (!we_q) rdata_d = ext_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`endif

  // Stall in the same cycle a command appears, and for the whole access.
  assign busy       = ((state_q == IDLE) && cmd) || (state_q == ACCESS);
  assign read_data  = rdata_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit.
// Stimulus pushes the expected memory request and the expected completion.
// A monitor pops and checks them when the DUT raises dmem_req and when busy
// drops (the DONE cycle). A small memory model acks after mem_lat cycles.
module tb_data_mem_access_unit;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          nbusy;
  } rsp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  mem_read = '0;
  logic [2:0]  mem_write = '0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        busy, misaligned, dmem_req, dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int          n_chk = 0;
  int          n_fail = 0;
  req_t        req_q[$];
  rsp_t        rsp_q[$];
  int          mem_lat = 1;
  logic [31:0] mem_word = '0;
  logic        spur_ack = 1'b0;
  logic [31:0] last_rd = '0;

  data_mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .busy(busy), .misaligned(misaligned), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: ack on the mem_lat-th cycle of an asserted request.
  initial begin
    int cnt;
    cnt = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge CLK); #1;
      if (dmem_req) cnt++; else cnt = 0;
      if (dmem_req && cnt == mem_lat) begin
        dmem_ack = 1'b1;
        dmem_rdata = mem_word;
      end else begin
        dmem_ack = spur_ack;
      end
    end
  end

  // Monitor
  req_t cur;
  logic have_req = 1'b0;
  logic in_req = 1'b0;
  int   busy_cnt = 0;
  initial begin
    rsp_t r;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        busy_cnt = 0;
        in_req = 1'b0;
      end else begin
        if (dmem_req) begin
          if (!in_req) begin
            if (req_q.size() == 0) begin
              n_chk++; n_fail++; have_req = 1'b0;
              $display("FAIL unexpected_req: got addr %h we %b expected no request", dmem_addr, dmem_we);
            end else begin
              cur = req_q.pop_front();
              have_req = 1'b1;
            end
            in_req = 1'b1;
          end
          if (have_req) begin
            chk("dmem_we", {31'b0, dmem_we}, {31'b0, cur.we});
            chk("dmem_addr", {2'b0, dmem_addr}, {2'b0, cur.addr});
            if (cur.we) begin
              chk("dmem_be", {28'b0, dmem_be}, {28'b0, cur.be});
              chk("dmem_wdata", dmem_wdata, cur.wdata);
            end
          end
        end else begin
          in_req = 1'b0;
        end
        if (busy) busy_cnt++;
        else if (busy_cnt > 0) begin
          if (rsp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: got busy for %0d cycles expected no transaction", busy_cnt);
          end else begin
            r = rsp_q.pop_front();
            chk("read_data", read_data, r.rd);
            chk("misaligned", {31'b0, misaligned}, {31'b0, r.mis});
            chk("busy_cycles", busy_cnt, r.nbusy);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic xact(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                      input logic [31:0] wd, input int lat, input logic [31:0] word,
                      input logic has_req, input logic ewe, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic [31:0] erd, input logic emis,
                      input int ebusy);
    req_t rq;
    rsp_t rs;
    bit   done;
    if (has_req) begin
      rq.we = ewe; rq.addr = a[31:2]; rq.be = ebe; rq.wdata = ewd;
      req_q.push_back(rq);
    end
    rs.rd = erd; rs.mis = emis; rs.nbusy = ebusy;
    rsp_q.push_back(rs);
    @(posedge CLK); #1;
    mem_lat = lat; mem_word = word;
    mem_read = rd; mem_write = wr; address = a; write_data = wd;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!busy) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: got busy stuck high expected completion within 40 cycles");
    end
    @(posedge CLK); #1;
    mem_read = '0; mem_write = '0;
  endtask

  task automatic st(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input int lat, input logic [3:0] ebe, input logic [31:0] ewd);
    xact(4'b0000, {1'b1, f3}, a, wd, lat, 32'h0, 1'b1, 1'b1, ebe, ewd, last_rd, 1'b0, lat + 1);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word,
                    input int lat, input logic [31:0] erd);
    xact({1'b1, f3}, 3'b000, a, 32'h0, lat, word, 1'b1, 1'b0, 4'hF, 32'h0, erd, 1'b0, lat + 1);
    last_rd = erd;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"}, {31'b0, busy}, 32'h0);
    chk({nm, "_req"}, {31'b0, dmem_req}, 32'h0);
    chk({nm, "_rd"}, read_data, last_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_we", {31'b0, dmem_we}, 32'h0);
    chk("rst_be", {28'b0, dmem_be}, 32'h0);
    chk("rst_addr", {2'b0, dmem_addr}, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_rd", read_data, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'h0);
    RESET = 1'b1;

    // Stores
    st(2'b10, 32'h100, 32'hDEADBEEF, 2, 4'hF, 32'hDEADBEEF);
    st(2'b00, 32'h103, 32'h000000A5, 1, 4'b1000, 32'hA5A5A5A5);
    st(2'b01, 32'h102, 32'h1234BEEF, 3, 4'b1100, 32'hBEEFBEEF);
    st(2'b00, 32'h104, 32'h0000003C, 1, 4'b0001, 32'h3C3C3C3C);

    // Loads from 0x80FF7F01 (byte0=01 byte1=7F byte2=FF byte3=80)
    ld(3'b000, 32'h202, 32'h80FF7F01, 1, 32'hFFFFFFFF);
    ld(3'b100, 32'h202, 32'h80FF7F01, 2, 32'h000000FF);
    ld(3'b000, 32'h201, 32'h80FF7F01, 1, 32'h0000007F);
    ld(3'b100, 32'h201, 32'h80FF7F01, 1, 32'h0000007F);
    ld(3'b001, 32'h202, 32'h80FF7F01, 2, 32'hFFFF80FF);
    ld(3'b101, 32'h202, 32'h80FF7F01, 1, 32'h000080FF);
    ld(3'b001, 32'h200, 32'h80FF7F01, 1, 32'h00007F01);
    ld(3'b010, 32'h200, 32'h80FF7F01, 3, 32'h80FF7F01);
    ld(3'b011, 32'h204, 32'h12345678, 1, 32'h12345678);

    // Both enables: store wins, read_data unchanged
    xact(4'b1000, 3'b110, 32'h300, 32'hCAFEF00D, 2, 32'h11111111,
         1'b1, 1'b1, 4'hF, 32'hCAFEF00D, last_rd, 1'b0, 3);

    // Stray ack while idle
    @(negedge CLK); spur_ack = 1'b1;
    @(negedge CLK); spur_ack = 1'b0;
    @(negedge CLK); chk_quiet("idle_ack");
    @(negedge CLK); chk_quiet("idle_ack2");

    // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    xact(4'b1010, 3'b000, 32'h101, 32'h0, 1, 32'h55AA33CC,
         1'b0, 1'b0, 4'h0, 32'h0, last_rd, 1'b1, 1);
    xact(4'b1001, 3'b000, 32'h203, 32'h0, 1, 32'h80010000,
         1'b0, 1'b0, 4'h0, 32'h0, last_rd, 1'b1, 1);
`else
    ld(3'b010, 32'h101, 32'h55AA33CC, 1, 32'h55AA33CC);
    ld(3'b001, 32'h203, 32'h80010000, 2, 32'hFFFF8001);
`endif

    // Reset in the middle of an access
    begin
      req_t rq;
      rq.we = 1'b0; rq.addr = 30'h90; rq.be = 4'hF; rq.wdata = 32'h0;
      req_q.push_back(rq);
      @(posedge CLK); #1;
      mem_lat = 5; mem_word = 32'h77777777;
      mem_read = 4'b1010; address = 32'h240;
      repeat (2) @(negedge CLK);
      chk("mid_req_high", {31'b0, dmem_req}, 32'h1);
      #2;
      mem_read = '0;
      RESET = 1'b0;
      #1;
      last_rd = 32'h0;
      chk("mid_rst_req", {31'b0, dmem_req}, 32'h0);
      chk("mid_rst_busy", {31'b0, busy}, 32'h0);
      chk("mid_rst_be", {28'b0, dmem_be}, 32'h0);
      chk("mid_rst_addr", {2'b0, dmem_addr}, 32'h0);
      chk("mid_rst_rd", read_data, 32'h0);
      @(negedge CLK); #2;
      RESET = 1'b1;
      @(negedge CLK); spur_ack = 1'b1;
      @(negedge CLK); spur_ack = 1'b0;
      @(negedge CLK); chk_quiet("post_rst_ack");
    end

    ld(3'b101, 32'h206, 32'hABCD0000, 2, 32'h0000ABCD);
    st(2'b01, 32'h20C, 32'h00005A5A, 1, 4'b0011, 32'h5A5A5A5A);

    repeat (4) @(negedge CLK);
    chk("req_q_empty", req_q.size(), 32'h0);
    chk("rsp_q_empty", rsp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
